// File: rtl/bram_port_arbiter_pkg.sv
// Shared arbitration types for the BRAM port arbiter and the engine-side control.
package bram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_ENGINE = 1'b0,
    OWN_HOST   = 1'b1
  } owner_t;

  typedef struct packed {
    logic   vld;
    owner_t owner;
  } rd_tag_t;

endpackage

// File: rtl/bram_port_arbiter_tag_pipe.sv
// Read-tag delay line: carries {valid, owner} alongside the BRAM read latency.
module arb_tag_pipe
  import bram_port_arbiter_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic vld_i,
  input  logic owner_i,
  output logic vld_o,
  output logic owner_o
);

  rd_tag_t [RD_LAT-1:0] tag_pipe;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= '{vld: vld_i, owner: owner_t'(owner_i)};
      for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign vld_o   = tag_pipe[RD_LAT-1].vld;
  assign owner_o = tag_pipe[RD_LAT-1].owner;

endmodule

// File: rtl/bram_port_arbiter.sv
// Two-master arbiter for a single BRAM port: engine (A) vs host (B), with
// burst-length preemption and read-return steering by issue-time owner.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter  int s         = 16,
  parameter  int RD_LAT    = 2,
  parameter  int MAX_BURST = 64,
  localparam int AW        = $clog2(4*s)
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          a_req_i,
  input  logic          a_en_i,
  input  logic          a_we_i,
  input  logic [AW-1:0] a_addr_i,
  input  logic [16:0]   a_din_i,
  input  logic          b_req_i,
  input  logic          b_en_i,
  input  logic          b_we_i,
  input  logic [AW-1:0] b_addr_i,
  input  logic [31:0]   b_din_i,
  input  logic [31:0]   BRAM_dout_i,
  output logic          a_gnt_o,
  output logic          b_gnt_o,
  output logic          BRAM_en_o,
  output logic          BRAM_we_o,
  output logic [AW-1:0] BRAM_addr_o,
  output logic [31:0]   BRAM_din_o,
  output logic [31:0]   rdata_o,
  output logic          a_rvalid_o,
  output logic          b_rvalid_o,
  output logic          violation_o
);

  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t    state_q, state_d;
  owner_t        last_q, last_d;
  logic [CW-1:0] cnt_q;
  logic          burst_end;
  logic          viol_q;
  logic          tag_vld, tag_host;

  assign a_gnt_o   = (state_q == OWN_A);
  assign b_gnt_o   = (state_q == OWN_B);
  // >= so a requester arriving after the counter saturated still gets in
  assign burst_end = (cnt_q >= CW'(MAX_BURST - 1));

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (a_req_i && b_req_i) state_d = (last_q == OWN_HOST) ? OWN_A : OWN_B;
        else if (a_req_i)       state_d = OWN_A;
        else if (b_req_i)       state_d = OWN_B;
      end
      OWN_A: begin
        if (!a_req_i || (b_req_i && burst_end)) begin
          state_d = IDLE;
          last_d  = OWN_ENGINE;
        end
      end
      OWN_B: begin
        if (!b_req_i || (a_req_i && burst_end)) begin
          state_d = IDLE;
          last_d  = OWN_HOST;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Every ownership passes through IDLE, so clearing there clears on entry
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      last_q  <= OWN_HOST;
      cnt_q   <= '0;
      viol_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      if (state_q == IDLE)             cnt_q <= '0;
      else if (cnt_q != CW'(MAX_BURST)) cnt_q <= cnt_q + 1'b1;
      if ((a_en_i && !a_gnt_o) || (b_en_i && !b_gnt_o)) viol_q <= 1'b1;
    end
  end

  always_comb begin
    BRAM_en_o   = 1'b0;
    BRAM_we_o   = 1'b0;
    BRAM_addr_o = '0;
    BRAM_din_o  = '0;
    if (a_gnt_o) begin
      BRAM_en_o   = a_en_i;
      BRAM_we_o   = a_we_i;
      BRAM_addr_o = a_addr_i;
      BRAM_din_o  = {15'd0, a_din_i};
    end else if (b_gnt_o) begin
      BRAM_en_o   = b_en_i;
      BRAM_we_o   = b_we_i;
      BRAM_addr_o = b_addr_i;
      BRAM_din_o  = b_din_i;
    end
  end

  arb_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .vld_i   (BRAM_en_o & ~BRAM_we_o),
    .owner_i (b_gnt_o),
    .vld_o   (tag_vld),
    .owner_o (tag_host)
  );

  assign rdata_o     = BRAM_dout_i;
  assign a_rvalid_o  = tag_vld & ~tag_host;
  assign b_rvalid_o  = tag_vld &  tag_host;
  assign violation_o = viol_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench: BRAM model behind the arbiter, read returns scored from a queue.
module tb_bram_port_arbiter;

  localparam int S      = 16;
  localparam int RD_LAT = 2;
  localparam int MAXB   = 8;
  localparam int AW     = $clog2(4*S);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req = 0, a_en = 0, a_we = 0;
  logic [AW-1:0] a_addr = '0;
  logic [16:0]   a_din = '0;
  logic          b_req = 0, b_en = 0, b_we = 0;
  logic [AW-1:0] b_addr = '0;
  logic [31:0]   b_din = '0;
  logic [31:0]   bram_dout;
  logic          a_gnt, b_gnt, bram_en, bram_we;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_din, rdata;
  logic          a_rvalid, b_rvalid, violation;

  bram_port_arbiter #(.s(S), .RD_LAT(RD_LAT), .MAX_BURST(MAXB)) dut (
    .clock_i(clk), .reset_i(rst_n),
    .a_req_i(a_req), .a_en_i(a_en), .a_we_i(a_we), .a_addr_i(a_addr), .a_din_i(a_din),
    .b_req_i(b_req), .b_en_i(b_en), .b_we_i(b_we), .b_addr_i(b_addr), .b_din_i(b_din),
    .BRAM_dout_i(bram_dout),
    .a_gnt_o(a_gnt), .b_gnt_o(b_gnt),
    .BRAM_en_o(bram_en), .BRAM_we_o(bram_we), .BRAM_addr_o(bram_addr), .BRAM_din_o(bram_din),
    .rdata_o(rdata), .a_rvalid_o(a_rvalid), .b_rvalid_o(b_rvalid), .violation_o(violation)
  );

  always #5 clk = ~clk;

  // BRAM model: synchronous write, RD_LAT-cycle read
  logic [31:0] mem [4*S];
  logic [31:0] rd_pipe [RD_LAT];
  logic        loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      mem[5] <= 32'h0001_ABCD;
      loaded <= 1'b1;
    end else if (bram_en && bram_we) begin
      mem[bram_addr] <= bram_din;
    end
    rd_pipe[0] <= (bram_en && !bram_we) ? mem[bram_addr] : 32'h0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bram_dout = rd_pipe[RD_LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        owner_a;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rd(input logic owner_a, input logic [31:0] data);
    exp_t e;
    e.owner_a = owner_a;
    e.data    = data;
    e.due     = cyc + RD_LAT;
    sb.push_back(e);
  endtask

  // Scoreboard: returns must land exactly on their due cycle, nothing else may pulse
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk("a_rvalid_ret", {31'd0, a_rvalid}, {31'd0, e.owner_a});
        chk("b_rvalid_ret", {31'd0, b_rvalid}, {31'd0, !e.owner_a});
        chk("rdata_ret", rdata, e.data);
      end else begin
        chk("a_rvalid_quiet", {31'd0, a_rvalid}, 32'd0);
        chk("b_rvalid_quiet", {31'd0, b_rvalid}, 32'd0);
      end
    end
  end

  task automatic chk_gnt(input string tag, input logic ea, input logic eb);
    chk({tag, "_a_gnt"}, {31'd0, a_gnt}, {31'd0, ea});
    chk({tag, "_b_gnt"}, {31'd0, b_gnt}, {31'd0, eb});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk_gnt("rst", 1'b0, 1'b0);
    chk("rst_en", {31'd0, bram_en}, 32'd0);
    chk("rst_we", {31'd0, bram_we}, 32'd0);
    chk("rst_addr", {26'd0, bram_addr}, 32'd0);
    chk("rst_din", bram_din, 32'd0);
    chk("rst_viol", {31'd0, violation}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    #1;
    mon_en = 1'b1;
    do_reset();

    // Engine-only read of addr 5 on grant cycle 3
    tick(); a_req = 1;
    tick(); chk_gnt("a1", 1'b1, 1'b0);
    tick();
    tick(); a_en = 1; a_addr = 6'd5; push_rd(1'b1, 32'h0001_ABCD);
    #1;
    chk("rd_en", {31'd0, bram_en}, 32'd1);
    chk("rd_we", {31'd0, bram_we}, 32'd0);
    chk("rd_addr", {26'd0, bram_addr}, 32'd5);
    tick(); a_en = 0; a_addr = '0;
    tick();
    tick(); a_req = 0;
    tick(); chk_gnt("a_rel", 1'b0, 1'b0);

    // Tie after reset goes to A; one bubble, then B
    do_reset();
    tick(); a_req = 1; b_req = 1;
    for (int k = 1; k <= 4; k++) begin
      tick(); chk_gnt("tie_a", 1'b1, 1'b0);
    end
    a_req = 0;
    tick(); chk_gnt("tie_bubble", 1'b0, 1'b0);
    tick(); chk_gnt("tie_b", 1'b0, 1'b1);
    b_en = 1; b_we = 1; b_addr = 6'd9; b_din = 32'hDEAD_BEEF;
    #1;
    chk("bwr_we", {31'd0, bram_we}, 32'd1);
    chk("bwr_din", bram_din, 32'hDEAD_BEEF);
    chk("bwr_addr", {26'd0, bram_addr}, 32'd9);
    tick(); b_en = 0; b_we = 0; b_req = 0;
    tick(); chk_gnt("b_rel", 1'b0, 1'b0);

    // A burst preempted by B after MAXB cycles, A reads on its last cycle
    a_req = 1;
    tick(); chk_gnt("pre_a1", 1'b1, 1'b0);
    a_en = 1; a_we = 1; a_addr = 6'd10; a_din = 17'h1FFFF;
    #1; chk("awr_din_zext", bram_din, 32'h0001_FFFF);
    tick(); a_en = 0; a_we = 0; b_req = 1;
    for (int k = 2; k < MAXB; k++) begin
      chk_gnt("pre_hold", 1'b1, 1'b0);
      tick();
    end
    chk_gnt("pre_last", 1'b1, 1'b0);
    a_en = 1; a_addr = 6'd10; push_rd(1'b1, 32'h0001_FFFF);
    tick(); a_en = 0; chk_gnt("pre_bubble", 1'b0, 1'b0);
    tick(); chk_gnt("pre_b", 1'b0, 1'b1);
    b_en = 1; b_addr = 6'd9; push_rd(1'b0, 32'hDEAD_BEEF);
    tick(); b_en = 0; b_req = 0;
    tick(); chk_gnt("pre_bubble2", 1'b0, 1'b0);
    tick(); chk_gnt("pre_regrant", 1'b1, 1'b0);
    a_req = 0;
    tick();
    tick(); chk_gnt("pre_done", 1'b0, 1'b0);

    // Host access without grant
    b_en = 1; b_we = 1; b_addr = 6'd3; b_din = 32'h55;
    #1;
    chk("viol_we_blocked", {31'd0, bram_we}, 32'd0);
    chk("viol_en_blocked", {31'd0, bram_en}, 32'd0);
    tick(); b_en = 0; b_we = 0;
    chk("viol_set", {31'd0, violation}, 32'd1);
    tick(); tick(); tick();
    chk("viol_sticky", {31'd0, violation}, 32'd1);
    do_reset();

    // Reset one cycle after an A read: the return must vanish
    tick(); a_req = 1;
    tick(); chk_gnt("r5_a", 1'b1, 1'b0);
    a_en = 1; a_addr = 6'd5;
    tick(); a_en = 0; rst_n = 1'b0;
    #1; chk_gnt("r5_rst", 1'b0, 1'b0);
    tick(); tick(); a_req = 0; rst_n = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    chk_gnt("r5_post", 1'b0, 1'b0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 Parameter s, default 16: number of 17-bit operand blocks; sets the address width.
REQ-002 Parameter RD_LAT, default 2: BRAM read latency in cycles; range 1..4.
REQ-003 Parameter MAX_BURST, default 64: cycles an owner may hold the port while the other side waits.
REQ-004 Derived localparam AW = $clog2(4*s).
REQ-005 clock_i  in  1: the single clock; all state on its rising edge.
REQ-006 reset_i  in  1: asynchronous, active-low reset.
REQ-007 a_req_i  in  1: engine (memory_control side) requests the port; held high for the whole burst.
REQ-008 a_en_i, a_we_i  in  1 each: engine BRAM enable and write strobe.
REQ-009 a_addr_i  in  AW: engine BRAM address.
REQ-010 a_din_i  in  17: engine write data (result block).
REQ-011 b_req_i, b_en_i, b_we_i  in  1 each: host (AXI side) request, enable and write strobe.
REQ-012 b_addr_i  in  AW: host address.
REQ-013 b_din_i  in  32: host write data.
REQ-014 BRAM_dout_i  in  32: BRAM read data.
REQ-015 a_gnt_o, b_gnt_o  out  1 each: port ownership, registered.
REQ-016 BRAM_en_o, BRAM_we_o  out  1 each; BRAM_addr_o  out  AW; BRAM_din_o  out  32: muxed BRAM port.
REQ-017 rdata_o  out  32: equal to BRAM_dout_i.
REQ-018 a_rvalid_o, b_rvalid_o  out  1 each: rdata_o belongs to engine or host this cycle.
REQ-019 violation_o  out  1: sticky flag; en asserted without grant.

Function
REQ-020 FSM states: IDLE, OWN_A, OWN_B. a_gnt_o = (state==OWN_A); b_gnt_o = (state==OWN_B).
REQ-021 IDLE, single request: go to that requester's OWN state on the next edge.
REQ-022 IDLE, both requesting: grant the side that is not last_owner; last_owner resets to B, so A wins the first tie.
REQ-023 OWN_x with x_req low: go to IDLE and set last_owner = x, giving one bubble cycle between owners.
REQ-024 Burst counter clears on entry to OWN_x and increments each cycle in OWN_x, saturating at MAX_BURST.
REQ-025 OWN_x, other side requesting, counter == MAX_BURST-1: preempt (go to IDLE, last_owner = x); the other side wins the next arbitration.
REQ-026 Preempted owner keeps req high and is re-granted after the other side releases; data integrity on preemption is the owner's responsibility.
REQ-027 BRAM_en_o/we_o/addr_o/din_o follow the owner's inputs combinationally when its grant is high; otherwise en/we = 0 and addr/din = 0.
REQ-028 a_din_i is zero-extended to 32 bits.
REQ-029 Read tag pipeline, RD_LAT stages of {valid, owner}: stage 0 loads valid = BRAM_en_o & ~BRAM_we_o, owner = current grantee.
REQ-030 x_rvalid_o is asserted exactly RD_LAT cycles after a read issued by x.
REQ-031 Tags survive ownership change and preemption, so in-flight reads return to the original issuer.
REQ-032 violation_o is set when (a_en_i & ~a_gnt_o) | (b_en_i & ~b_gnt_o) and is cleared only by reset; the offending access never reaches the BRAM.
REQ-033 Requests sampled in the same cycle a grant drops are evaluated in IDLE on the next cycle, never in the same cycle.

Reset
REQ-034 While reset_i = 0: state IDLE, last_owner B, counter 0, tag pipeline cleared, violation_o 0; all outputs 0 except rdata_o.
REQ-035 Reset asserted mid-burst aborts the burst and drops in-flight read valids; no rvalid pulse follows the release of reset.

Structure
REQ-036 Shared package holds the arb_state_t enum (IDLE, OWN_A, OWN_B) and the owner_t enum (OWN_ENGINE, OWN_HOST), reused by top_control.
REQ-037 One sub-module: arb_tag_pipe, a RD_LAT-deep shift register of {valid, owner} with asynchronous active-low clear.

Verification
REQ-038 a_req_i only, read addr 5 at cycle 3 of grant, BRAM returns 0x1ABCD -> a_rvalid_o high exactly 2 cycles later, rdata_o = 0x0001ABCD, b_rvalid_o never high.
REQ-039 a_req_i and b_req_i rise together after reset -> a_gnt_o first; A drops req after 4 cycles -> 1 IDLE cycle, then b_gnt_o.
REQ-040 MAX_BURST = 8, A holds, B requests at grant cycle 2 -> A grant drops after 8 grant cycles, B granted 2 cycles later, A re-granted after B releases.
REQ-041 A reads on its last grant cycle, then B is granted -> a_rvalid_o still pulses RD_LAT cycles after that read; b_rvalid_o stays low.
REQ-042 b_en_i = 1, b_we_i = 1 with no grant -> BRAM_we_o stays 0, violation_o = 1 and stays set until reset.
REQ-043 reset_i pulled low 1 cycle after an A read issues -> all grants low, no rvalid pulse at any time after reset releases.
